// File: rtl/m_cycle_sequencer.sv
// m_cycle_sequencer: M-cycle / T-phase sequencer for the CPU controller.
// Tracks the running M-cycle index and T-phase of each instruction, handles
// CB-prefix chaining, conditional early termination, stall freeze and the
// interrupt dispatch sequence.
// Optional HALT state: define M_CYCLE_SEQ_HALT_EN to build it; otherwise
// halt_req is ignored and halted is tied low.
module m_cycle_sequencer #(
   parameter int T_PER_M      = 4,
   parameter int CNT_W        = 3,
   parameter int INT_M_CYCLES = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ce,
   input  logic                       stall,
   input  logic [CNT_W-1:0]           op_len,
   input  logic                       is_prefix,
   input  logic [CNT_W-1:0]           prefix_len,
   input  logic                       cond_fail,
   input  logic                       irq_take,
   input  logic                       irq_pending,
   input  logic                       halt_req,
   output logic [CNT_W-1:0]           m_cycle,
   output logic [$clog2(T_PER_M)-1:0] t_phase,
   output logic                       m_end,
   output logic                       instr_end,
   output logic                       fetch,
   output logic                       in_prefix,
   output logic                       in_irq,
   output logic                       halted
);

   localparam int TP_W = $clog2(T_PER_M);

   localparam logic [TP_W-1:0]  T_LAST   = TP_W'(T_PER_M - 1);
   localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(INT_M_CYCLES - 1);

   if (T_PER_M < 2) begin : g_bad_t_per_m
      $error("m_cycle_sequencer: T_PER_M must be >= 2");
   end
   if (INT_M_CYCLES < 1 || INT_M_CYCLES > (2 ** CNT_W)) begin : g_bad_int_m
      $error("m_cycle_sequencer: INT_M_CYCLES must be in 1..2**CNT_W");
   end

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_EXEC,
      ST_PFETCH,
      ST_PEXEC,
      ST_INT
`ifdef M_CYCLE_SEQ_HALT_EN
      ,
      ST_HALT
`endif
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] m_d;
   logic [CNT_W-1:0] op_len_q;
   logic [CNT_W-1:0] op_len_d;
   logic [CNT_W-1:0] prefix_len_q;
   logic [CNT_W-1:0] prefix_len_d;
   logic             last_m;

`ifndef M_CYCLE_SEQ_HALT_EN
   logic unused_halt_inputs;
   assign unused_halt_inputs = halt_req ^ irq_pending;
   assign halted             = 1'b0;
`endif

   // Next-state decode; every transition is qualified by m_end so a stall or
   // ce=0 leaves state, index and latched lengths untouched.
   always_comb begin
      m_end        = ce & ~stall & (t_phase == T_LAST);
      state_d      = state_q;
      m_d          = m_cycle;
      op_len_d     = op_len_q;
      prefix_len_d = prefix_len_q;
      last_m       = 1'b0;

      if (m_end) begin
         unique case (state_q)
            ST_FETCH: begin
               op_len_d = op_len;
               if (is_prefix) begin
                  state_d = ST_PFETCH;
                  m_d     = '0;
               end else if (op_len != '0) begin
                  state_d = ST_EXEC;
                  m_d     = CNT_W'(1);
               end else begin
                  last_m = 1'b1;
               end
            end
            ST_EXEC: begin
               if ((m_cycle == op_len_q) || cond_fail) begin
                  last_m = 1'b1;
               end else begin
                  m_d = m_cycle + CNT_W'(1);
               end
            end
            ST_PFETCH: begin
               prefix_len_d = prefix_len;
               if (prefix_len == '0) begin
                  last_m = 1'b1;
               end else begin
                  state_d = ST_PEXEC;
                  m_d     = CNT_W'(1);
               end
            end
            ST_PEXEC: begin
               if (m_cycle == prefix_len_q) begin
                  last_m = 1'b1;
               end else begin
                  m_d = m_cycle + CNT_W'(1);
               end
            end
            ST_INT: begin
               if (m_cycle == INT_LAST) begin
                  state_d = ST_FETCH;
                  m_d     = '0;
               end else begin
                  m_d = m_cycle + CNT_W'(1);
               end
            end
`ifdef M_CYCLE_SEQ_HALT_EN
            ST_HALT: begin
               m_d = '0;
               if (irq_pending) begin
                  state_d = irq_take ? ST_INT : ST_FETCH;
               end
            end
`endif
            default: begin
               state_d = ST_FETCH;
               m_d     = '0;
            end
         endcase

         // Common end-of-instruction exit; HALT only reachable from a
         // single-M-cycle opcode ending in FETCH, and it outranks irq_take.
         if (last_m) begin
            state_d = irq_take ? ST_INT : ST_FETCH;
            m_d     = '0;
`ifdef M_CYCLE_SEQ_HALT_EN
            if ((state_q == ST_FETCH) && halt_req) begin
               state_d = ST_HALT;
            end
`endif
         end
      end

      instr_end = last_m;
   end

   // State, counters, latched lengths and registered state-flag outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         m_cycle      <= '0;
         t_phase      <= '0;
         op_len_q     <= '0;
         prefix_len_q <= '0;
         fetch        <= 1'b1;
         in_prefix    <= 1'b0;
         in_irq       <= 1'b0;
`ifdef M_CYCLE_SEQ_HALT_EN
         halted       <= 1'b0;
`endif
      end else begin
         if (ce && !stall) begin
            t_phase <= (t_phase == T_LAST) ? '0 : t_phase + TP_W'(1);
         end
         state_q      <= state_d;
         m_cycle      <= m_d;
         op_len_q     <= op_len_d;
         prefix_len_q <= prefix_len_d;
         fetch        <= (state_d == ST_FETCH) || (state_d == ST_PFETCH);
         in_prefix    <= (state_d == ST_PFETCH) || (state_d == ST_PEXEC);
         in_irq       <= (state_d == ST_INT);
`ifdef M_CYCLE_SEQ_HALT_EN
         halted       <= (state_d == ST_HALT);
`endif
      end
   end

endmodule

// File: tb/tb_m_cycle_sequencer.sv
// Self-checking bench for m_cycle_sequencer. Each instruction is expanded
// into a list of expected M-cycle records (index, state flags, last-cycle
// marker and the inputs to present); records are then played out with random
// ce gaps and stalls while the T-phase and strobes are checked every clock.
module tb_m_cycle_sequencer;

   localparam int T_PER_M      = 4;
   localparam int CNT_W        = 3;
   localparam int INT_M_CYCLES = 5;
`ifdef M_CYCLE_SEQ_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             ce;
   logic             stall;
   logic [CNT_W-1:0] op_len;
   logic             is_prefix;
   logic [CNT_W-1:0] prefix_len;
   logic             cond_fail;
   logic             irq_take;
   logic             irq_pending;
   logic             halt_req;
   logic [CNT_W-1:0] m_cycle;
   logic [1:0]       t_phase;
   logic             m_end;
   logic             instr_end;
   logic             fetch;
   logic             in_prefix;
   logic             in_irq;
   logic             halted;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   typedef struct {
      int       m;
      bit       f;
      bit       p;
      bit       i;
      bit       h;
      bit       last;
      bit [2:0] op_len;
      bit [2:0] plen;
      bit       is_pfx;
      bit       cf;
      bit       itake;
      bit       ipend;
      bit       hreq;
   } mrec_t;

   mrec_t q[$];

   m_cycle_sequencer #(
      .T_PER_M     (T_PER_M),
      .CNT_W       (CNT_W),
      .INT_M_CYCLES(INT_M_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .stall      (stall),
      .op_len     (op_len),
      .is_prefix  (is_prefix),
      .prefix_len (prefix_len),
      .cond_fail  (cond_fail),
      .irq_take   (irq_take),
      .irq_pending(irq_pending),
      .halt_req   (halt_req),
      .m_cycle    (m_cycle),
      .t_phase    (t_phase),
      .m_end      (m_end),
      .instr_end  (instr_end),
      .fetch      (fetch),
      .in_prefix  (in_prefix),
      .in_irq     (in_irq),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Record with the given expected outputs and random (don't-care) inputs.
   function automatic mrec_t mk(int m, bit f, bit p, bit i, bit h, bit last);
      mrec_t r;
      r.m      = m;
      r.f      = f;
      r.p      = p;
      r.i      = i;
      r.h      = h;
      r.last   = last;
      r.op_len = 3'($urandom);
      r.plen   = 3'($urandom);
      r.is_pfx = 1'($urandom);
      r.cf     = 1'($urandom);
      r.itake  = 1'($urandom);
      r.ipend  = 1'($urandom);
      r.hreq   = 1'($urandom);
      return r;
   endfunction

   task automatic push_int();
      for (int m = 0; m < INT_M_CYCLES; m++) q.push_back(mk(m, 0, 0, 1, 0, 0));
   endtask

   // Expand one instruction (plus any HALT / interrupt tail) into records.
   // cf: EXEC M-cycle whose end sees cond_fail=1 (0 = never).
   task automatic gen_instr(int olen, bit pfx, int plen, int cf, bit irq, bit hlt);
      mrec_t r;
      bit    halting;
      bit    irq2;
      int    e;
      int    k;
      r        = mk(0, 1, 0, 0, 0, !pfx && olen == 0);
      r.op_len = 3'(olen);
      r.is_pfx = pfx;
      r.hreq   = hlt;
      if (r.last) r.itake = irq;
      q.push_back(r);
      if (pfx) begin
         r      = mk(0, 1, 1, 0, 0, plen == 0);
         r.plen = 3'(plen);
         if (r.last) r.itake = irq;
         q.push_back(r);
         for (int m = 1; m <= plen; m++) begin
            r = mk(m, 0, 1, 0, 0, m == plen);
            if (r.last) r.itake = irq;
            q.push_back(r);
         end
      end else if (olen > 0) begin
         e = (cf > 0) ? cf : olen;
         for (int m = 1; m <= e; m++) begin
            r    = mk(m, 0, 0, 0, 0, m == e);
            r.cf = (m == cf);
            if (r.last) r.itake = irq;
            q.push_back(r);
         end
      end
      halting = HALT_EN && hlt && !pfx && olen == 0;
      if (halting) begin
         k = int'($urandom_range(3, 0));
         for (int j = 0; j < k; j++) begin
            r       = mk(0, 0, 0, 0, 1, 0);
            r.ipend = 1'b0;
            q.push_back(r);
         end
         r       = mk(0, 0, 0, 0, 1, 0);
         r.ipend = 1'b1;
         irq2    = r.itake;
         q.push_back(r);
         if (irq2) push_int();
      end else if (irq) begin
         push_int();
      end
   endtask

   // Play one M-cycle record: T_PER_M advancing ticks, with random idle/stall clocks.
   task automatic run_rec(input mrec_t r);
      int tt    = 0;
      int guard = 0;
      bit adv;
      while (tt < T_PER_M && guard < 400) begin
         @(negedge clk);
         ce          = ($urandom % 4) != 0;
         stall       = ce && (($urandom % 8) == 0);
         op_len      = r.op_len;
         is_prefix   = r.is_pfx;
         prefix_len  = r.plen;
         cond_fail   = r.cf;
         irq_take    = r.itake;
         irq_pending = r.ipend;
         halt_req    = r.hreq;
         #1;
         adv = ce && !stall;
         check_eq("t_phase", t_phase, tt);
         check_eq("m_cycle", m_cycle, r.m);
         check_eq("fetch", fetch, r.f);
         check_eq("in_prefix", in_prefix, r.p);
         check_eq("in_irq", in_irq, r.i);
         check_eq("halted", halted, r.h);
         check_eq("m_end", m_end, adv && tt == T_PER_M - 1);
         check_eq("instr_end", instr_end, adv && tt == T_PER_M - 1 && r.last);
         if (adv) tt++;
         guard++;
      end
      if (tt < T_PER_M) check_eq("record_timeout", 1, 0);
   endtask

   task automatic run_queue();
      while (q.size() > 0) run_rec(q.pop_front());
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_t_phase"}, t_phase, 0);
      check_eq({tag, "_m_cycle"}, m_cycle, 0);
      check_eq({tag, "_fetch"}, fetch, 1);
      check_eq({tag, "_in_prefix"}, in_prefix, 0);
      check_eq({tag, "_in_irq"}, in_irq, 0);
      check_eq({tag, "_halted"}, halted, 0);
   endtask

   initial begin
      int olen;
      int plen;
      int cf;
      bit pfx;
      bit irq;
      bit hlt;

      reset       = 1'b1;
      ce          = 1'b0;
      stall       = 1'b0;
      op_len      = '0;
      is_prefix   = 1'b0;
      prefix_len  = '0;
      cond_fail   = 1'b0;
      irq_take    = 1'b0;
      irq_pending = 1'b0;
      halt_req    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_state("reset");

      // Reset in the middle of an EXEC cycle abandons the instruction.
      ce     = 1'b1;
      op_len = 3'd5;
      repeat (6) @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("pre_reset_m_cycle", m_cycle, 1);
      check_eq("pre_reset_t_phase", t_phase, 2);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      ce     = 1'b0;
      op_len = '0;
      #1;
      check_reset_state("mid_reset");

      // Directed cases: NOP, CALL, failed branch, CB prefix, max length, HALT.
      gen_instr(0, 0, 0, 0, 0, 0);
      gen_instr(5, 0, 0, 0, 0, 0);
      gen_instr(4, 0, 0, 1, 0, 0);
      gen_instr(0, 1, 2, 0, 0, 0);
      gen_instr(7, 0, 0, 0, 1, 0);
      gen_instr(0, 0, 0, 0, 1, 1);
      gen_instr(0, 1, 7, 0, 0, 0);
      gen_instr(0, 1, 0, 0, 1, 0);
      gen_instr(0, 0, 0, 0, 0, 1);
      run_queue();

      for (int n = 0; n < 250; n++) begin
         olen = int'($urandom_range(7, 0));
         pfx  = ($urandom % 6) == 0;
         plen = int'($urandom_range(7, 0));
         cf   = (olen > 0 && ($urandom % 3) == 0) ? int'($urandom_range(olen, 1)) : 0;
         irq  = ($urandom % 4) == 0;
         hlt  = 1'b0;
         if (($urandom % 6) == 0) begin
            olen = 0;
            pfx  = 1'b0;
            hlt  = 1'b1;
         end
         gen_instr(olen, pfx, plen, cf, irq, hlt);
         run_queue();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
